// File: rtl/sobel_pkg.sv
// Shared types and default geometry for the Sobel line-buffer feeder and window logic.
// Counter widths derive from the frame geometry.
package sobel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } feeder_state_t;

  localparam int IMG_WIDTH_DEF  = 32;
  localparam int IMG_HEIGHT_DEF = 32;
  localparam int DATA_W_DEF     = 8;
  localparam int COL_W_DEF      = $clog2(IMG_WIDTH_DEF);
  localparam int ROW_W_DEF      = $clog2(IMG_HEIGHT_DEF);

endpackage

// File: rtl/sobel_raster_counter.sv
// Raster column/row position counter: advances one pixel per adv, wraps at frame end.
// Position is registered; last flags the final pixel of the frame combinationally.
module sobel_raster_counter
  import sobel_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH_DEF,
  parameter int HEIGHT = IMG_HEIGHT_DEF,
  localparam int COL_W = $clog2(WIDTH),
  localparam int ROW_W = $clog2(HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             col_end;
  logic             row_end;

  always_comb begin
    col_end = (col_q == COL_W'(WIDTH - 1));
    row_end = (row_q == ROW_W'(HEIGHT - 1));
    col_d   = col_q;
    row_d   = row_q;
    if (adv) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = col_end && row_end;

endmodule

// File: rtl/sobel_pixel_feeder.sv
// Feeds raster pixels into the cascaded line buffers; accept on N gives Enable/DataOut on N+1.
// Hold freezes everything and drops In_Ready; SOBEL_FEEDER_FLUSH_EN adds a 2*IMG_WIDTH zero flush.
module sobel_pixel_feeder
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  localparam int COL_W     = $clog2(IMG_WIDTH),
  localparam int ROW_W     = $clog2(IMG_HEIGHT)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              Hold,
  output logic              Enable,
  output logic [DATA_W-1:0] DataOut,
  output logic              Window_Valid,
  output logic [ROW_W-1:0]  Row,
  output logic [COL_W-1:0]  Col,
  output logic              Frame_Done
);

  feeder_state_t     state_q, state_d;
  logic              enable_q, enable_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              wv_q, wv_d;
  logic              done_q, done_d;

  logic              accept;
  logic [COL_W-1:0]  cnt_col;
  logic [ROW_W-1:0]  cnt_row;
  logic              cnt_last;

`ifdef SOBEL_FEEDER_FLUSH_EN
  localparam int FLUSH_N = 2 * IMG_WIDTH;
  localparam int FLUSH_W = $clog2(FLUSH_N);
  logic [FLUSH_W-1:0] flush_q, flush_d;
`endif

  assign In_Ready = ((state_q == ST_IDLE) || (state_q == ST_STREAM)) && !Hold;
  assign accept   = In_Valid && In_Ready;

  sobel_raster_counter #(
    .WIDTH  (IMG_WIDTH),
    .HEIGHT (IMG_HEIGHT)
  ) u_pos (
    .clk  (CLK),
    .rst  (RST),
    .adv  (accept),
    .col  (cnt_col),
    .row  (cnt_row),
    .last (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    enable_d = 1'b0;
    data_d   = data_q;
    row_d    = row_q;
    col_d    = col_q;
    wv_d     = 1'b0;
    done_d   = 1'b0;
`ifdef SOBEL_FEEDER_FLUSH_EN
    flush_d  = flush_q;
`endif

    if (accept) begin
      enable_d = 1'b1;
      data_d   = In_Data;
      row_d    = cnt_row;
      col_d    = cnt_col;
      wv_d     = (int'(cnt_row) >= 2) && (int'(cnt_col) >= 2);
`ifdef SOBEL_FEEDER_FLUSH_EN
      state_d  = cnt_last ? ST_FLUSH : ST_STREAM;
`else
      state_d  = cnt_last ? ST_DONE : ST_STREAM;
`endif
    end

    case (state_q)
      ST_FLUSH: begin
`ifdef SOBEL_FEEDER_FLUSH_EN
        // Zero shifts scrub both line buffers so the next frame starts clean.
        if (!Hold) begin
          enable_d = 1'b1;
          data_d   = '0;
          row_d    = '0;
          col_d    = '0;
          if (flush_q == FLUSH_W'(FLUSH_N - 1)) begin
            flush_d = '0;
            state_d = ST_DONE;
          end else begin
            flush_d = flush_q + 1'b1;
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        // Stay one extra cycle so the pulse is seen while In_Ready is still low.
        if (done_q) begin
          state_d = ST_IDLE;
        end else if (!Hold) begin
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      enable_q <= 1'b0;
      data_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      wv_q     <= 1'b0;
      done_q   <= 1'b0;
`ifdef SOBEL_FEEDER_FLUSH_EN
      flush_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      data_q   <= data_d;
      row_q    <= row_d;
      col_q    <= col_d;
      wv_q     <= wv_d;
      done_q   <= done_d;
`ifdef SOBEL_FEEDER_FLUSH_EN
      flush_q  <= flush_d;
`endif
    end
  end

  assign Enable       = enable_q;
  assign DataOut      = data_q;
  assign Row          = row_q;
  assign Col          = col_q;
  assign Window_Valid = wv_q;
  assign Frame_Done   = done_q;

endmodule

// File: doc/sobel_pixel_feeder.md
# sobel_pixel_feeder

Stream-side driver for the Sobel line-buffer chain. Accepts raster-order 8-bit pixels from an upstream valid/ready source and issues them as `Enable`/`DataOut` shift pulses into two cascaded `IMG_WIDTH`-deep line buffers. It tracks row and column position, flags when a full 3x3 window is present in the chain, and signals end of frame. It is the write side of the line-buffer interface, placed between the frame source and the buffer/window logic.

## Interface
- `IMG_WIDTH`, 32: pixels per row; must equal line-buffer depth; ≥3
- `IMG_HEIGHT`, 32: rows per frame; ≥3
- `DATA_W`, 8: pixel width
- `CLK`  in  1  single clock; all logic on its rising edge
- `RST`  in  1  synchronous, active-high reset
- `In_Valid`  in  1  upstream pixel valid
- `In_Ready`  out  1  feeder can accept a pixel this cycle
- `In_Data`  in  DATA_W  upstream pixel
- `Hold`  in  1  downstream freeze request; no shifts while high
- `Enable`  out  1  one-cycle shift strobe to the line-buffer chain
- `DataOut`  out  DATA_W  pixel presented with `Enable`
- `Window_Valid`  out  1  high with `Enable` when the shifted pixel completes a valid 3x3 window
- `Row`  out  $clog2(IMG_HEIGHT)  row of the pixel on `DataOut`
- `Col`  out  $clog2(IMG_WIDTH)  column of the pixel on `DataOut`
- `Frame_Done`  out  1  one-cycle pulse after the last pixel (or after flush)

## Operation
- States: IDLE, STREAM, FLUSH, DONE. Reset → IDLE; all outputs 0; counters 0.
- `In_Ready` = (state ∈ {IDLE, STREAM}) && !`Hold`.
- A pixel is accepted on a cycle where `In_Valid && In_Ready`. IDLE → STREAM on the first accept.
- Each accept registers `In_Data` to `DataOut`, pulses `Enable` for exactly one cycle, and drives `Row`/`Col` with the accepted pixel's position. The column counter then advances. It wraps at `IMG_WIDTH`-1 to 0 and increments the row.
- `Window_Valid` = `Enable` && `Row` ≥ 2 && `Col` ≥ 2.
- Accept of pixel (`IMG_HEIGHT`-1, `IMG_WIDTH`-1) → DONE, or → FLUSH when flush is enabled. Counters return to 0.
- DONE: pulse `Frame_Done` for one cycle, then → IDLE.
- With `Hold` high: no accept and no `Enable` in any state. The state, counters and flush count are frozen. `DataOut` keeps its last value.
- `Enable` is low on every cycle without an accept or flush shift. `DataOut` is don't-care when `Enable` is low but holds its last value.
- Reset mid-frame: the next cycle is IDLE with counters 0. A pending `Enable` is dropped, and no `Frame_Done` is issued.

## Timing
- Latency: accept on cycle N → `Enable`/`DataOut`/`Row`/`Col`/`Window_Valid` on cycle N+1.
- Throughput: one pixel per cycle when `In_Valid` is high and `Hold` is low.
- `In_Ready` is combinational from state and `Hold` only. It never depends on `In_Valid`.
- Last accept on cycle N → `Frame_Done` high on cycle N+2 when flush is disabled. `In_Ready` is low on cycle N+1 and N+2, and high again on N+3.

## Configuration
- `SOBEL_FEEDER_FLUSH_EN` defined: FLUSH state present. It issues 2×`IMG_WIDTH` shifts with `DataOut` = 0 and `Enable` high, one per non-held cycle.
  - During flush, `Window_Valid` = 0 and `In_Ready` = 0.
  - After the final flush shift → DONE. The line buffers hold zeros before the next frame.
- Undefined: no FLUSH state. The last accept goes directly to DONE, and stale line contents remain.

## Structure
- Shared package `sobel_pkg`: state enum (IDLE/STREAM/FLUSH/DONE), default `IMG_WIDTH`/`IMG_HEIGHT`/`DATA_W` constants, and counter-width localparams derived by `$clog2`.
- One natural sub-module: `sobel_raster_counter`, the column/row counter with enable, wrap and last-pixel flag. It is reused by the window side.

## Test plan
- Reset with `RST`=1 for 2 cycles → all outputs 0, `In_Ready`=1 after release, state IDLE.
- `IMG_WIDTH`=4, `IMG_HEIGHT`=4, continuous valid with pixels 0..15:
  - → 16 `Enable` pulses on consecutive cycles, each one cycle after its accept.
  - → `Window_Valid` exactly on pixels 10, 11, 14, 15.
  - → `Frame_Done` 2 cycles after accepting pixel 15.
- Same frame with `In_Valid` toggling every cycle → 16 `Enable` pulses total, and `Row`/`Col` match each pixel's raster position.
- `Hold` high for 3 cycles mid-row (after pixel 5) → no `Enable`, `In_Ready`=0 for those 3 cycles; pixel 6 resumes with `Col`=2, `Row`=1.
- `RST` pulsed after pixel 9 → no `Frame_Done`; the next frame's first pixel reports `Row`=0, `Col`=0 and no `Window_Valid` until pixel 10.
- With `SOBEL_FEEDER_FLUSH_EN`, 4x4 frame → 8 zero-data `Enable` pulses after pixel 15 with `Window_Valid`=0 and `In_Ready`=0, then `Frame_Done`.
